// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two
// requesters. A single operation is in flight at a time: accept, hold the
// registered operands for ALU_LAT cycles, sample the result, then hand it
// back on the winner's response channel.
module alu_share_arbiter #(
    parameter int WIDTH   = 5,
    parameter int SEL_W   = 2,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             grant_id,
    output logic [CNT_W-1:0] op_count
);

    localparam int LAT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic [LAT_W-1:0] wait_cnt;
    logic             pick;
    logic             accept;
    logic             exec_done;
    logic             resp_hs;

    assign busy = (state == EXEC) || (state == RESP);

    // State register; reset drops any operation that is still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Round-robin selection, ready generation and next-state decode.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        exec_done  = 1'b0;
        resp_hs    = 1'b0;
        pick       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        case (state)
            IDLE: begin
                req0_ready = (req0_valid || req1_valid) && !pick;
                req1_ready = (req0_valid || req1_valid) && pick;
                accept     = req0_valid || req1_valid;
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                exec_done = (wait_cnt == LAT_W'(1));
                if (exec_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_hs = grant_id ? resp1_ready : resp0_ready;
                if (resp_hs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand bus and grant bookkeeping; the ALU only ever sees registered values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            alu_a      <= pick ? req1_a : req0_a;
            alu_b      <= pick ? req1_b : req0_b;
            alu_sel    <= pick ? req1_sel : req0_sel;
            grant_id   <= pick;
            last_grant <= pick;
        end else if (resp_hs) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end
    end

    // Wait counter: loaded on accept, counts the cycles the operands are held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= LAT_W'(ALU_LAT);
        end else if (state == EXEC) begin
            wait_cnt <= wait_cnt - LAT_W'(1);
        end
    end

    // Response registers; data is kept after the handshake, valid is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_data  <= '0;
            resp1_data  <= '0;
        end else if (exec_done) begin
            if (grant_id) begin
                resp1_valid <= 1'b1;
                resp1_data  <= alu_result;
            end else begin
                resp0_valid <= 1'b1;
                resp0_data  <= alu_result;
            end
        end else if (resp_hs) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end
    end

    // Completed-operation counter, wraps naturally at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (resp_hs) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance with ALU_LAT=1 for the
// main scenarios and one with ALU_LAT=3 for the latency check.
module tb_alu_share_arbiter;

    logic       clk;
    logic       rst_n;

    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_sel, req1_sel;
    logic       resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [4:0] resp0_data, resp1_data;
    logic [4:0] alu_a, alu_b, alu_result;
    logic [1:0] alu_sel;
    logic       busy, grant_id;
    logic [7:0] op_count;

    logic       b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
    logic [4:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
    logic [1:0] b_req0_sel, b_req1_sel;
    logic       b_resp0_valid, b_resp0_ready, b_resp1_valid, b_resp1_ready;
    logic [4:0] b_resp0_data, b_resp1_data;
    logic [4:0] b_alu_a, b_alu_b, b_alu_result;
    logic [1:0] b_alu_sel;
    logic       b_busy, b_grant_id;
    logic [7:0] b_op_count;

    int check_count = 0;
    int pass_count  = 0;

    // Bench ALU: 00 add, 01 subtract, 10 and, 11 xor (all mod 32).
    function automatic logic [4:0] alu_model(input logic [4:0] a, input logic [4:0] b,
                                             input logic [1:0] sel);
        case (sel)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result   = alu_model(alu_a, alu_b, alu_sel);
    assign b_alu_result = alu_model(b_alu_a, b_alu_b, b_alu_sel);

    alu_share_arbiter #(.WIDTH(5), .SEL_W(2), .ALU_LAT(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .busy(busy), .grant_id(grant_id), .op_count(op_count)
    );

    alu_share_arbiter #(.WIDTH(5), .SEL_W(2), .ALU_LAT(3), .CNT_W(8)) dut_lat3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
        .req0_a(b_req0_a), .req0_b(b_req0_b), .req0_sel(b_req0_sel),
        .resp0_valid(b_resp0_valid), .resp0_ready(b_resp0_ready), .resp0_data(b_resp0_data),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
        .req1_a(b_req1_a), .req1_b(b_req1_b), .req1_sel(b_req1_sel),
        .resp1_valid(b_resp1_valid), .resp1_ready(b_resp1_ready), .resp1_data(b_resp1_data),
        .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_sel(b_alu_sel), .alu_result(b_alu_result),
        .busy(b_busy), .grant_id(b_grant_id), .op_count(b_op_count)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request on the ALU_LAT=1 instance.
    task automatic applyStimulus(input int req, input logic [4:0] a, input logic [4:0] b,
                                 input logic [1:0] sel);
        if (req == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
        end
    endtask

    int   grants [6];
    int   times  [6];
    int   n_acc;
    logic prev_busy;
    logic overlap;

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0; resp0_ready = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0; resp1_ready = 0;
        b_req0_valid = 0; b_req0_a = 0; b_req0_b = 0; b_req0_sel = 0; b_resp0_ready = 0;
        b_req1_valid = 0; b_req1_a = 0; b_req1_b = 0; b_req1_sel = 0; b_resp1_ready = 0;
        tick();
        tick();
        checkOutput("rst_resp0_valid", 32'(resp0_valid), 0);
        checkOutput("rst_resp1_valid", 32'(resp1_valid), 0);
        checkOutput("rst_resp0_data", 32'(resp0_data), 0);
        checkOutput("rst_resp1_data", 32'(resp1_data), 0);
        checkOutput("rst_alu_bus", 32'({alu_a, alu_b, alu_sel}), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_grant_id", 32'(grant_id), 0);
        checkOutput("rst_op_count", 32'(op_count), 0);
        rst_n = 1'b1;
        tick();

        // Single request: 31 + 17 = 48 -> 16
        applyStimulus(0, 5'b11111, 5'b10001, 2'b00);
        resp0_ready = 1'b1;
        #1;
        checkOutput("single_req0_ready", 32'(req0_ready), 1);
        checkOutput("single_req1_ready", 32'(req1_ready), 0);
        tick();
        checkOutput("single_alu_a", 32'(alu_a), 31);
        checkOutput("single_alu_b", 32'(alu_b), 17);
        checkOutput("single_busy", 32'(busy), 1);
        checkOutput("single_ready_busy", 32'(req0_ready), 0);
        checkOutput("single_resp_early", 32'(resp0_valid), 0);
        req0_valid = 1'b0;
        tick();
        checkOutput("single_resp0_valid", 32'(resp0_valid), 1);
        checkOutput("single_resp0_data", 32'(resp0_data), 16);
        checkOutput("single_resp1_valid", 32'(resp1_valid), 0);
        tick();
        checkOutput("single_hs_valid", 32'(resp0_valid), 0);
        checkOutput("single_op_count", 32'(op_count), 1);
        checkOutput("single_idle_busy", 32'(busy), 0);
        checkOutput("single_alu_cleared", 32'({alu_a, alu_b, alu_sel}), 0);
        checkOutput("single_data_kept", 32'(resp0_data), 16);

        // Reset in the middle of EXEC
        applyStimulus(0, 5'd1, 5'd2, 2'b00);
        tick();
        req0_valid = 1'b0;
        checkOutput("midrst_busy_before", 32'(busy), 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_alu_bus", 32'({alu_a, alu_b, alu_sel}), 0);
        checkOutput("midrst_op_count", 32'(op_count), 0);
        checkOutput("midrst_resp_data", 32'({resp0_data, resp1_data}), 0);
        tick();
        rst_n = 1'b1;
        overlap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (resp0_valid || resp1_valid || busy) overlap = 1'b1;
        end
        checkOutput("midrst_no_resp", 32'(overlap), 0);

        // Simultaneous requests after reset: req0 wins first
        resp1_ready = 1'b1;
        applyStimulus(0, 5'b00011, 5'b00001, 2'b00);
        applyStimulus(1, 5'b00101, 5'b00010, 2'b00);
        #1;
        checkOutput("simul_req0_ready", 32'(req0_ready), 1);
        checkOutput("simul_req1_ready", 32'(req1_ready), 0);
        tick();
        req0_valid = 1'b0;
        checkOutput("simul_grant0", 32'(grant_id), 0);
        checkOutput("simul_req1_wait", 32'(req1_ready), 0);
        tick();
        checkOutput("simul_resp0_data", 32'(resp0_data), 4);
        checkOutput("simul_resp_pair0", 32'({resp0_valid, resp1_valid}), 2);
        tick();
        checkOutput("simul_req1_ready_now", 32'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        checkOutput("simul_grant1", 32'(grant_id), 1);
        tick();
        checkOutput("simul_resp1_data", 32'(resp1_data), 7);
        checkOutput("simul_resp_pair1", 32'({resp0_valid, resp1_valid}), 1);
        tick();
        checkOutput("simul_op_count", 32'(op_count), 2);

        // Fairness: both valid continuously for six operations
        applyStimulus(0, 5'd1, 5'd1, 2'b00);
        applyStimulus(1, 5'd2, 5'd2, 2'b00);
        n_acc = 0;
        overlap = 1'b0;
        prev_busy = busy;
        for (int cyc = 0; cyc < 40 && n_acc < 6; cyc++) begin
            tick();
            if (resp0_valid && resp1_valid) overlap = 1'b1;
            if (busy && !prev_busy) begin
                grants[n_acc] = 32'(grant_id);
                times[n_acc]  = cyc;
                n_acc++;
                if (n_acc == 6) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
            prev_busy = busy;
        end
        checkOutput("fair_accepts", 32'(n_acc), 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("fair_grant%0d", i), 32'(grants[i]), 32'(i % 2));
        end
        for (int i = 1; i < 6; i++) begin
            checkOutput($sformatf("fair_interval%0d", i), 32'(times[i] - times[i-1]), 3);
        end
        checkOutput("fair_no_overlap", 32'(overlap), 0);
        tick();
        tick();
        tick();
        checkOutput("fair_op_count", 32'(op_count), 8);

        // Response backpressure on requester 1: 9 - 4 = 5
        resp1_ready = 1'b0;
        applyStimulus(1, 5'd9, 5'd4, 2'b01);
        tick();
        req1_valid = 1'b0;
        applyStimulus(0, 5'd2, 5'd6, 2'b10);
        checkOutput("bp_grant1", 32'(grant_id), 1);
        tick();
        overlap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!resp1_valid || resp1_data !== 5'd5 || !busy || req0_ready) overlap = 1'b1;
        end
        checkOutput("bp_hold_stable", 32'(overlap), 0);
        checkOutput("bp_resp1_data", 32'(resp1_data), 5);
        resp1_ready = 1'b1;
        tick();
        checkOutput("bp_hs_valid", 32'(resp1_valid), 0);
        checkOutput("bp_req0_ready", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        checkOutput("bp_grant0", 32'(grant_id), 0);
        checkOutput("bp_alu_a", 32'(alu_a), 2);
        tick();
        checkOutput("bp_resp0_data", 32'(resp0_data), 2);
        tick();
        checkOutput("bp_op_count", 32'(op_count), 10);

        // Counter wrap: 246 more operations take op_count from 10 through 255 to 0
        applyStimulus(0, 5'd1, 5'd0, 2'b00);
        repeat (737) tick();
        checkOutput("wrap_255", 32'(op_count), 255);
        tick();
        req0_valid = 1'b0;
        checkOutput("wrap_0", 32'(op_count), 0);

        // ALU_LAT=3 instance: 7 ^ 9 = 14, result three cycles after accept
        b_req0_valid = 1'b1; b_req0_a = 5'd7; b_req0_b = 5'd9; b_req0_sel = 2'b11;
        b_resp0_ready = 1'b1;
        #1;
        checkOutput("lat3_req0_ready", 32'(b_req0_ready), 1);
        tick();
        b_req0_valid = 1'b0;
        checkOutput("lat3_alu_a", 32'(b_alu_a), 7);
        checkOutput("lat3_resp_c0", 32'(b_resp0_valid), 0);
        tick();
        checkOutput("lat3_resp_c1", 32'(b_resp0_valid), 0);
        tick();
        checkOutput("lat3_resp_c2", 32'(b_resp0_valid), 0);
        checkOutput("lat3_alu_held", 32'({b_alu_a, b_alu_b, b_alu_sel}), 32'({5'd7, 5'd9, 2'b11}));
        tick();
        checkOutput("lat3_resp_c3", 32'(b_resp0_valid), 1);
        checkOutput("lat3_resp_data", 32'(b_resp0_data), 14);
        tick();
        checkOutput("lat3_op_count", 32'(b_op_count), 1);
        checkOutput("lat3_idle", 32'(b_busy), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational 5-bit ALU between two requesters. Each requester presents a, b and select over a valid/ready handshake. The block arbitrates round-robin, drives the ALU operand/select bus and samples the ALU result. It then returns the result to the winning requester over a per-requester valid/ready response channel. Only one operation is in flight at a time; the block sits between the requesters and the ALU instance.

Parameters:
WIDTH, 5, operand/result width
SEL_W, 2, ALU select width
ALU_LAT, 1, cycles operands are held before the result is sampled; must be >= 1
CNT_W, 8, width of the completed-operation counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accept; combinational
req0_a, req0_b  in  WIDTH  requester 0 operands
req0_sel  in  SEL_W  requester 0 ALU select
resp0_valid  out  1  result available for requester 0
resp0_ready  in  1  requester 0 takes result
resp0_data  out  WIDTH  result for requester 0
req1_valid, req1_ready, req1_a, req1_b, req1_sel  as above  requester 1 request channel
resp1_valid, resp1_ready, resp1_data  as above  requester 1 response channel
alu_a, alu_b  out  WIDTH  registered operands to the ALU
alu_sel  out  SEL_W  registered select to the ALU
alu_result  in  WIDTH  ALU output (ALU's "sum" port)
busy  out  1  high in EXEC or RESP
grant_id  out  1  requester owning the current operation
op_count  out  CNT_W  completed responses; wraps

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: resp*_valid, resp*_data, alu_a, alu_b, alu_sel, busy, grant_id, op_count.
  - last_grant=1, so requester 0 wins first.
  - An in-flight operation is discarded; no response is issued after reset.
- States: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready=1 only for the selected requester; both readys are 0 in every other state.
  - Selection when only one requester is valid: that requester.
  - Selection when both are valid: the one not equal to last_grant.
  - Selection when neither is valid: both readys 0.
- Accept (valid&ready at edge T):
  - Latch a, b and sel into alu_a, alu_b and alu_sel.
  - Set grant_id and last_grant to the accepted requester.
  - Load wait counter with ALU_LAT; state moves to EXEC.
- EXEC:
  - alu_* are held stable; the counter decrements each edge.
  - At edge T+ALU_LAT, sample alu_result into respN_data of grant_id, set respN_valid, and move to RESP.
- RESP:
  - respN_valid and respN_data are held stable until respN_ready=1.
  - On the handshake edge: clear respN_valid, increment op_count (255 wraps to 0), and return to IDLE.
  - respN_data keeps its last value after the handshake.
- Latency and throughput:
  - resp_valid rises ALU_LAT cycles after the accept edge.
  - Minimum issue interval with resp_ready held high is ALU_LAT+2 cycles.
- alu_a, alu_b and alu_sel return to 0 on entry to IDLE. busy=1 iff state is EXEC or RESP.
- The non-granted respM_valid is always 0.
- A request held valid while busy sees ready=0 and must hold its fields. Dropping valid before accept has no effect.
- resp_ready asserted while resp_valid=0 is ignored.
- No operands are combinationally passed to the ALU; the ALU sees registered values only.

Test Plan:
- Bench ALU model: sel=00 computes a+b mod 32, other selects are bench-defined.
- Reset mid-EXEC: assert rst_n=0 one cycle after accept -> all outputs 0 immediately (asynchronous), no resp_valid afterwards, op_count=0.
- Single request, ALU_LAT=1: req0 a=11111 b=10001 sel=00, resp0_ready=1 -> req0_ready=1 in the accept cycle; alu_a=11111 after the edge; resp0_valid one cycle later with resp0_data=10000; op_count=1.
- Simultaneous requests after reset: req0 a=00011 b=00001, req1 a=00101 b=00010, both sel=00 -> req0 served first (resp0_data=00100), then req1 (resp1_data=00111); resp1_valid never overlaps resp0_valid.
- Fairness: both valid continuously for 6 operations -> grant_id alternates 0,1,0,1,0,1; issue interval is 3 cycles.
- Response backpressure: resp1_ready=0 for 5 cycles -> resp1_valid/resp1_data stable, busy=1, req0_ready=0 throughout; accepted the cycle after the resp1 handshake.
- Counter wrap and ALU_LAT=3: run 256 ops -> op_count reads 0; with ALU_LAT=3, resp_valid rises 3 cycles after accept.
